// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the MIPS hazard scoreboard.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int NSTAGES_DEF = 3;
    localparam int FSEL_W_DEF  = $clog2(NSTAGES_DEF + 1);

    // One in-flight register write tracked after decode
    typedef struct packed {
        logic       valid;
        logic       wen;
        logic [4:0] wsel;
        logic       is_load;
    } sb_slot_t;

    // EX operand select: 0 = register file, k = stage k latch
    typedef logic [FSEL_W_DEF-1:0] fwd_sel_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    // Build an occupied scoreboard slot from decode fields
    function automatic sb_slot_t make_slot(input logic wen, input logic [4:0] wsel,
                                           input logic is_load);
        sb_slot_t s;
        s.valid   = 1'b1;
        s.wen     = wen;
        s.wsel    = wsel;
        s.is_load = is_load;
        return s;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard query and hazard-unit response bundle.
// Latency: stall/flush combinational, forward selects registered.
// Backpressure: pipe_en gates every state update; stall holds IF/ID.
interface hazard_scoreboard_if #(
    parameter int NSTAGES = 3,
    parameter int CNT_W   = 16
);
    localparam int FSEL_W = $clog2(NSTAGES + 1);

    logic              pipe_en;
    logic              dec_valid;
    logic [4:0]        dec_rs;
    logic [4:0]        dec_rt;
    logic              dec_use_rs;
    logic              dec_use_rt;
    logic              dec_wen;
    logic [4:0]        dec_wsel;
    logic              dec_is_load;
    logic              dec_jump;
    logic              ex_br_taken;
    logic              stall;
    logic              flush_if;
    logic              flush_id;
    logic [FSEL_W-1:0] fwd_a;
    logic [FSEL_W-1:0] fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output pipe_en, dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
               dec_wen, dec_wsel, dec_is_load, dec_jump, ex_br_taken,
        input  stall, flush_if, flush_id, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  pipe_en, dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt,
               dec_wen, dec_wsel, dec_is_load, dec_jump, ex_br_taken,
        output stall, flush_if, flush_id, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Finds the youngest scoreboard slot writing a given source register.
// Latency: purely combinational.
// Backpressure: none.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int NSTAGES = 3,
    parameter int FSEL_W  = 2
) (
    input  sb_slot_t          slots_i [NSTAGES],
    input  logic              en_i,
    input  logic [4:0]        src_i,
    output logic              hit_o,
    output logic [FSEL_W-1:0] stage_o,
    output logic              is_load_o
);

    // Scan oldest to youngest so the lowest matching slot wins
    always_comb begin
        hit_o     = 1'b0;
        stage_o   = '0;
        is_load_o = 1'b0;
        for (int i = NSTAGES - 1; i >= 0; i--) begin
            if (en_i && slots_i[i].valid && slots_i[i].wen && (slots_i[i].wsel == src_i)) begin
                hit_o     = 1'b1;
                stage_o   = FSEL_W'(i + 1);
                is_load_o = slots_i[i].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: scoreboard of in-flight writes, stall/flush, forward selects, perf counters.
// Latency: stall/flush zero-cycle; fwd_a/fwd_b registered into EX on pipe_en.
// Backpressure: pipe_en low freezes slots, selects and counters; stall holds PC and IF/ID.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NSTAGES  = 3,
    parameter int FWD_EN   = 1,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    hazard_scoreboard_if.slave hz
);

    localparam int               FSEL_W  = $clog2(NSTAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sb_slot_t          slot_q [NSTAGES];
    sb_slot_t          slot_d [NSTAGES];
    logic              use_a, use_b;
    logic              hit_a, hit_b, ld_a, ld_b;
    logic [FSEL_W-1:0] j_a, j_b;
    logic [FSEL_W-1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;
    logic              stall_raw, stall, flush_if, flush_id, issue;
    logic [CNT_W-1:0]  stall_cnt_d, stall_cnt_q, flush_cnt_d, flush_cnt_q;

    // $0 and unread operands never create a dependency
    assign use_a = hz.dec_valid & hz.dec_use_rs & (hz.dec_rs != 5'd0);
    assign use_b = hz.dec_valid & hz.dec_use_rt & (hz.dec_rt != 5'd0);

    hazard_match #(.NSTAGES(NSTAGES), .FSEL_W(FSEL_W)) u_match_a (
        .slots_i   (slot_q),
        .en_i      (use_a),
        .src_i     (hz.dec_rs),
        .hit_o     (hit_a),
        .stage_o   (j_a),
        .is_load_o (ld_a)
    );

    hazard_match #(.NSTAGES(NSTAGES), .FSEL_W(FSEL_W)) u_match_b (
        .slots_i   (slot_q),
        .en_i      (use_b),
        .src_i     (hz.dec_rt),
        .hit_o     (hit_b),
        .stage_o   (j_b),
        .is_load_o (ld_b)
    );

    // Raw stall: load data not yet forwardable, or any in-flight producer when forwarding is off
    always_comb begin
        stall_raw = 1'b0;
        if (FWD_EN != 0) begin
            if (hit_a && ld_a && (int'(j_a) < LOAD_LAT)) stall_raw = 1'b1;
            if (hit_b && ld_b && (int'(j_b) < LOAD_LAT)) stall_raw = 1'b1;
        end else begin
            if (hit_a && (int'(j_a) < NSTAGES)) stall_raw = 1'b1;
            if (hit_b && (int'(j_b) < NSTAGES)) stall_raw = 1'b1;
        end
    end

    // A taken branch overrides the stall; a stalled jump waits before squashing IF/ID
    always_comb begin
        stall    = stall_raw & ~hz.ex_br_taken;
        flush_id = hz.ex_br_taken;
        flush_if = hz.ex_br_taken | (hz.dec_valid & hz.dec_jump & ~stall);
        issue    = hz.dec_valid & ~stall & ~flush_id;
    end

    // Forward selects for the instruction entering EX; bubbles read the register file
    always_comb begin
        fwd_a_d = '0;
        fwd_b_d = '0;
        if ((FWD_EN != 0) && issue && hit_a && (int'(j_a) < NSTAGES)) fwd_a_d = j_a;
        if ((FWD_EN != 0) && issue && hit_b && (int'(j_b) < NSTAGES)) fwd_b_d = j_b;
    end

    // Scoreboard shift: issuing instruction or bubble enters slot 0
    always_comb begin
        slot_d[0] = issue ? make_slot(hz.dec_wen, hz.dec_wsel, hz.dec_is_load) : '0;
        for (int i = 1; i < NSTAGES; i++) begin
            slot_d[i] = slot_q[i-1];
        end
    end

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_if && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // All state advances only when the pipeline advances
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NSTAGES; i++) begin
                slot_q[i] <= '0;
            end
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (hz.pipe_en) begin
            for (int i = 0; i < NSTAGES; i++) begin
                slot_q[i] <= slot_d[i];
            end
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall     = stall;
    assign hz.flush_if  = flush_if;
    assign hz.flush_id  = flush_id;
    assign hz.fwd_a     = fwd_a_q;
    assign hz.fwd_b     = fwd_b_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: forwarding and no-forwarding instances share one decode stream.
// Latency: checks stall/flush on the falling edge, registered outputs 1 time unit after the rising edge.
// Backpressure: pipe_en is driven both directed and random.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NST  = 3;
    localparam int LLAT = 2;

    logic       CLK;
    logic       nRST;
    logic       pipe_en, dec_valid, dec_use_rs, dec_use_rt, dec_wen, dec_is_load, dec_jump, ex_br_taken;
    logic [4:0] dec_rs, dec_rt, dec_wsel;

    hazard_scoreboard_if #(.NSTAGES(NST), .CNT_W(16)) hif_a ();
    hazard_scoreboard_if #(.NSTAGES(NST), .CNT_W(4))  hif_b ();

    assign hif_a.pipe_en = pipe_en;         assign hif_b.pipe_en = pipe_en;
    assign hif_a.dec_valid = dec_valid;     assign hif_b.dec_valid = dec_valid;
    assign hif_a.dec_rs = dec_rs;           assign hif_b.dec_rs = dec_rs;
    assign hif_a.dec_rt = dec_rt;           assign hif_b.dec_rt = dec_rt;
    assign hif_a.dec_use_rs = dec_use_rs;   assign hif_b.dec_use_rs = dec_use_rs;
    assign hif_a.dec_use_rt = dec_use_rt;   assign hif_b.dec_use_rt = dec_use_rt;
    assign hif_a.dec_wen = dec_wen;         assign hif_b.dec_wen = dec_wen;
    assign hif_a.dec_wsel = dec_wsel;       assign hif_b.dec_wsel = dec_wsel;
    assign hif_a.dec_is_load = dec_is_load; assign hif_b.dec_is_load = dec_is_load;
    assign hif_a.dec_jump = dec_jump;       assign hif_b.dec_jump = dec_jump;
    assign hif_a.ex_br_taken = ex_br_taken; assign hif_b.ex_br_taken = ex_br_taken;

    hazard_scoreboard #(.NSTAGES(NST), .FWD_EN(1), .LOAD_LAT(LLAT), .CNT_W(16)) u_dut_a (
        .CLK (CLK), .nRST (nRST), .hz (hif_a)
    );
    hazard_scoreboard #(.NSTAGES(NST), .FWD_EN(0), .LOAD_LAT(LLAT), .CNT_W(4)) u_dut_b (
        .CLK (CLK), .nRST (nRST), .hz (hif_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: each instance is a queue of in-flight writes, index k = stage k+1
    typedef struct packed {bit valid; bit wen; bit [4:0] wsel; bit ld;} ent_t;
    ent_t mq_a[$];
    ent_t mq_b[$];
    int   m_fa[2], m_fb[2], m_sc[2], m_fc[2], cmax[2];
    bit   e_st[2], e_fi[2], e_fd[2];
    int   e_fa[2], e_fb[2];
    logic o_st[2], o_fi[2], o_fd[2];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stage of the youngest in-flight writer of src (0 = none)
    function automatic void producer(input ent_t q[$], input bit en, input bit [4:0] src,
                                     output int stg, output bit ld);
        stg = 0;
        ld  = 0;
        if (en) begin
            foreach (q[k]) begin
                if (stg == 0 && q[k].valid && q[k].wen && q[k].wsel == src) begin
                    stg = k + 1;
                    ld  = q[k].ld;
                end
            end
        end
    endfunction

    function automatic void predict(input ent_t q[$], input bit fwd_en, output bit st,
                                    output bit fi, output bit fd, output int fa, output int fb);
        int ja, jb;
        bit la, lb, raw;
        producer(q, dec_valid && dec_use_rs && dec_rs != 0, dec_rs, ja, la);
        producer(q, dec_valid && dec_use_rt && dec_rt != 0, dec_rt, jb, lb);
        if (fwd_en) raw = (ja != 0 && la && ja < LLAT) || (jb != 0 && lb && jb < LLAT);
        else        raw = (ja != 0 && ja < NST) || (jb != 0 && jb < NST);
        st = raw && !ex_br_taken;
        fd = ex_br_taken;
        fi = ex_br_taken || (dec_valid && dec_jump && !st);
        fa = (fwd_en && ja != 0 && ja < NST) ? ja : 0;
        fb = (fwd_en && jb != 0 && jb < NST) ? jb : 0;
    endfunction

    task automatic model_reset();
        mq_a.delete();
        mq_b.delete();
        repeat (NST) begin
            mq_a.push_back('0);
            mq_b.push_back('0);
        end
        for (int d = 0; d < 2; d++) begin
            m_fa[d] = 0; m_fb[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
        end
    endtask

    task automatic advance(input int d);
        bit   issue;
        ent_t e;
        issue = dec_valid && !e_st[d] && !e_fd[d];
        e = '0;
        if (issue) begin
            e.valid = 1'b1; e.wen = dec_wen; e.wsel = dec_wsel; e.ld = dec_is_load;
        end
        if (d == 0) begin mq_a.push_front(e); void'(mq_a.pop_back()); end
        else        begin mq_b.push_front(e); void'(mq_b.pop_back()); end
        m_fa[d] = issue ? e_fa[d] : 0;
        m_fb[d] = issue ? e_fb[d] : 0;
        if (e_st[d] && m_sc[d] < cmax[d]) m_sc[d]++;
        if (e_fi[d] && m_fc[d] < cmax[d]) m_fc[d]++;
    endtask

    // One clock: compare combinational outputs, advance model, compare registered outputs
    task automatic tick();
        @(negedge CLK);
        predict(mq_a, 1'b1, e_st[0], e_fi[0], e_fd[0], e_fa[0], e_fb[0]);
        predict(mq_b, 1'b0, e_st[1], e_fi[1], e_fd[1], e_fa[1], e_fb[1]);
        o_st[0] = hif_a.stall; o_fi[0] = hif_a.flush_if; o_fd[0] = hif_a.flush_id;
        o_st[1] = hif_b.stall; o_fi[1] = hif_b.flush_if; o_fd[1] = hif_b.flush_id;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("stall%0d", d), o_st[d], e_st[d]);
            chk($sformatf("flush_if%0d", d), o_fi[d], e_fi[d]);
            chk($sformatf("flush_id%0d", d), o_fd[d], e_fd[d]);
        end
        @(posedge CLK);
        if (pipe_en) begin
            advance(0);
            advance(1);
        end
        #1;
        chk("fwd_a0", hif_a.fwd_a, m_fa[0]);         chk("fwd_b0", hif_a.fwd_b, m_fb[0]);
        chk("stall_cnt0", hif_a.stall_cnt, m_sc[0]); chk("flush_cnt0", hif_a.flush_cnt, m_fc[0]);
        chk("fwd_a1", hif_b.fwd_a, m_fa[1]);         chk("fwd_b1", hif_b.fwd_b, m_fb[1]);
        chk("stall_cnt1", hif_b.stall_cnt, m_sc[1]); chk("flush_cnt1", hif_b.flush_cnt, m_fc[1]);
    endtask

    task automatic set_ins(input bit [5:0] op, input bit [5:0] funct, input bit [4:0] rs,
                           input bit [4:0] rt, input bit [4:0] wsel, input bit urs,
                           input bit urt, input bit wen);
        dec_valid   = 1'b1;
        dec_rs      = rs;   dec_rt = rt;   dec_wsel = wsel;
        dec_use_rs  = urs;  dec_use_rt = urt;  dec_wen = wen;
        dec_is_load = (op == OP_LW);
        dec_jump    = (op == OP_J) || (op == OP_JAL) || (op == 6'd0 && funct == FUNCT_JR);
        ex_br_taken = 1'b0;
    endtask

    initial begin
        cmax[0] = 65535;
        cmax[1] = 15;
        pipe_en = 1'b1;
        nRST    = 1'b0;
        set_ins(6'd0, 6'd0, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1);
        model_reset();

        // Reset state
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_stall_a", hif_a.stall, 0);   chk("rst_stall_b", hif_b.stall, 0);
        chk("rst_fwd_a", hif_a.fwd_a, 0);     chk("rst_fwd_b", hif_a.fwd_b, 0);
        chk("rst_scnt", hif_a.stall_cnt, 0);  chk("rst_fcnt", hif_a.flush_cnt, 0);
        @(posedge CLK);
        #2 nRST = 1'b1;

        // Load-use: lw $2 then add $3,$2,$4
        set_ins(OP_LW, 6'd0, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1);
        tick();
        set_ins(6'd0, 6'd0, 5'd2, 5'd4, 5'd3, 1'b1, 1'b1, 1'b1);
        tick();
        chk("lu_stall", o_st[0], 1);
        chk("lu_scnt", hif_a.stall_cnt, 1);
        tick();
        chk("lu_stall_clr", o_st[0], 0);
        chk("lu_fwd_a", hif_a.fwd_a, 2);

        // ALU back-to-back: add $5 then sub $6,$1,$5
        set_ins(6'd0, 6'd0, 5'd1, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1);
        tick();
        set_ins(6'd0, 6'd0, 5'd1, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1);
        tick();
        chk("alu_stall", o_st[0], 0);
        chk("alu_fwd_b", hif_a.fwd_b, 1);
        chk("alu_fwd_a", hif_a.fwd_a, 0);

        // Youngest producer of $7 wins
        set_ins(6'd0, 6'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        set_ins(6'd0, 6'd0, 5'd7, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1);
        tick();
        chk("young_fwd_a", hif_a.fwd_a, 1);

        // $0 never matches even when a slot writes $0
        set_ins(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        set_ins(6'd0, 6'd0, 5'd0, 5'd0, 5'd15, 1'b1, 1'b1, 1'b1);
        tick();
        chk("r0_stall_a", o_st[0], 0);   chk("r0_stall_b", o_st[1], 0);
        chk("r0_fwd_a", hif_a.fwd_a, 0); chk("r0_fwd_b", hif_a.fwd_b, 0);

        // Taken branch overrides a load-use stall and issues a bubble
        set_ins(OP_LW, 6'd0, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
        tick();
        set_ins(6'd0, 6'd0, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1);
        ex_br_taken = 1'b1;
        tick();
        chk("br_stall", o_st[0], 0); chk("br_fi", o_fi[0], 1); chk("br_fd", o_fd[0], 1);
        set_ins(6'd0, 6'd0, 5'd10, 5'd9, 5'd11, 1'b1, 1'b1, 1'b1);
        tick();
        chk("br_bubble_stall", o_st[0], 0);
        chk("br_bubble_fwd_a", hif_a.fwd_a, 0);
        chk("br_bubble_fwd_b", hif_a.fwd_b, 2);

        // Stalled JR does not flush until the stall clears
        set_ins(OP_LW, 6'd0, 5'd1, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1);
        tick();
        set_ins(6'd0, FUNCT_JR, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("jr_stall", o_st[0], 1); chk("jr_no_flush", o_fi[0], 0);
        tick();
        chk("jr_stall_clr", o_st[0], 0); chk("jr_flush", o_fi[0], 1);
        chk("cnt_stall_a", hif_a.stall_cnt, 2);
        chk("cnt_flush_a", hif_a.flush_cnt, 2);

        // Reset asserted mid-stall drops the stall asynchronously
        set_ins(OP_LW, 6'd0, 5'd1, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1);
        tick();
        set_ins(6'd0, 6'd0, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        #1;
        chk("async_pre_a", hif_a.stall, 1);
        chk("async_pre_b", hif_b.stall, 1);
        nRST = 1'b0;
        #1;
        chk("async_stall_a", hif_a.stall, 0);
        chk("async_stall_b", hif_b.stall, 0);
        chk("async_scnt", hif_a.stall_cnt, 0);
        model_reset();
        @(posedge CLK);
        #2 nRST = 1'b1;

        // No-forward instance: add $8 then a dependent, pipe_en 1,0,1,1
        set_ins(6'd0, 6'd0, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1);
        tick();
        set_ins(6'd0, 6'd0, 5'd8, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1);
        tick();
        chk("nf_stall_1", o_st[1], 1);
        pipe_en = 1'b0;
        tick();
        chk("nf_stall_hold", o_st[1], 1);
        chk("nf_cnt_hold", hif_b.stall_cnt, 1);
        pipe_en = 1'b1;
        tick();
        chk("nf_stall_3", o_st[1], 1);
        tick();
        chk("nf_stall_clr", o_st[1], 0);
        chk("nf_fwd_a", hif_b.fwd_a, 0);
        chk("nf_scnt", hif_b.stall_cnt, 2);

        // Random decode stream against the model (also drives the 4-bit counters into saturation)
        for (int n = 0; n < 600; n++) begin
            pipe_en     = ($urandom_range(0, 3) != 0);
            dec_valid   = ($urandom_range(0, 7) != 0);
            dec_rs      = 5'($urandom_range(0, 7));
            dec_rt      = 5'($urandom_range(0, 7));
            dec_wsel    = 5'($urandom_range(0, 7));
            dec_use_rs  = 1'($urandom_range(0, 1));
            dec_use_rt  = 1'($urandom_range(0, 1));
            dec_wen     = ($urandom_range(0, 3) != 0);
            dec_is_load = ($urandom_range(0, 2) == 0);
            dec_jump    = ($urandom_range(0, 9) == 0);
            ex_br_taken = ($urandom_range(0, 11) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
